// File: rtl/instr_loader.sv
// Framed host-stream to instruction-FIFO write front end (header, N opcodes, optional XOR checksum).
// Optional checksum byte and err reporting enabled by defining LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  full,
  output logic                  wr,
  output logic [DATA_WIDTH-1:0] opcode,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] count
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, FIN} state_e;
`else
  typedef enum logic [1:0] {IDLE, LOAD, FIN} state_e;
`endif

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] len_q, len_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_vld_q, hold_vld_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] cnt_inc;
  logic                  rdy, wr_c;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] xor_q, xor_d;
  logic                  err_q, err_d;
`endif

  assign cnt_inc = cnt_q + ONE;
  assign wr_c    = (state_q == LOAD) && hold_vld_q && !full;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    acc_d      = acc_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    cnt_d      = cnt_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d      = xor_q;
    err_d      = err_q;
`endif
    rdy        = 1'b0;
    case (state_q)
      IDLE: begin
        rdy = 1'b1;
        // A zero-length header is swallowed without starting a program.
        if (in_valid && in_data != '0) begin
          len_d      = in_data;
          acc_d      = '0;
          cnt_d      = '0;
          hold_vld_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          xor_d      = '0;
          err_d      = 1'b0;
`endif
          state_d    = LOAD;
        end
      end
      LOAD: begin
        rdy = (acc_q < len_q) && (!hold_vld_q || !full);
        if (wr_c) begin
          hold_vld_d = 1'b0;
          cnt_d      = cnt_inc;
`ifdef LOADER_CHECKSUM_EN
          xor_d      = xor_q ^ hold_q;
          if (cnt_inc == len_q) state_d = CHECK;
`else
          if (cnt_inc == len_q) state_d = FIN;
`endif
        end
        // Refill in the same cycle the hold drains keeps 1 opcode/cycle.
        if (in_valid && rdy) begin
          hold_d     = in_data;
          hold_vld_d = 1'b1;
          acc_d      = acc_q + ONE;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        rdy = 1'b1;
        if (in_valid) begin
          err_d   = (in_data != xor_q);
          state_d = FIN;
        end
      end
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      acc_q      <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      cnt_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
      xor_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      acc_q      <= acc_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      cnt_q      <= cnt_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
      err_q      <= err_d;
`endif
    end
  end

  // Host must see not-ready while reset is held, even though state reads IDLE.
  assign in_ready = reset & rdy;
  assign wr       = wr_c;
  assign opcode   = hold_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign count    = cnt_q;
`ifdef LOADER_CHECKSUM_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected opcodes queued on acceptance, popped on wr.
module tb_instr_loader;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          full = 1'b0;
  logic          in_ready, wr, busy, done, err;
  logic [DW-1:0] opcode, count;

  instr_loader #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .full(full), .wr(wr), .opcode(opcode), .busy(busy),
    .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_bad = 0, cyc = 0;
  int          done_cnt = 0, wr_cnt = 0, first_wr = -1, last_wr = -1, exp_n = 0;
  bit          exp_err = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pl[256];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (reset) begin
    if (wr) begin
      chk("wr_nofull", {31'd0, full}, 0);
      if (exp_q.size() == 0) chk("wr_unexp", 1, 0);
      else chk("opcode", {24'd0, opcode}, {24'd0, exp_q.pop_front()});
      wr_cnt++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
    end
    if (done) begin
      done_cnt++;
      chk("count_done", {24'd0, count}, exp_n);
`ifdef LOADER_CHECKSUM_EN
      chk("err_done", {31'd0, err}, {31'd0, exp_err});
`else
      chk("err_zero", {31'd0, err}, 0);
      chk("done_lat", cyc, last_wr + 1);
`endif
      chk("q_empty", exp_q.size(), 0);
    end
  end

  task automatic send(input logic [DW-1:0] b);
    int t = 0;
    bit ok;
    in_valid = 1'b1;
    in_data  = b;
    do begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1; t++;
    end while (!ok && t < 1000);
    if (!ok) chk("send_to", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic frame(input int n, input bit gap, input bit bad);
    int d0 = done_cnt;
    int t = 0;
    logic [DW-1:0] x = '0;
    exp_n = n; first_wr = -1; last_wr = -1;
    send(DW'(n));
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      send(pl[i]);
      exp_q.push_back(pl[i]);
      x ^= pl[i];
    end
`ifdef LOADER_CHECKSUM_EN
    exp_err = bad;
    send(bad ? (x ^ 8'h01) : x);
`else
    if (bad) exp_err = 1'b0;
`endif
    while (done_cnt == d0 && t < 200) begin @(posedge clk); #1; t++; end
    chk("done_once", done_cnt, d0 + 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_single", done_cnt, d0 + 1);
    chk("busy_idle", {31'd0, busy}, 0);
    chk("count_hold", {24'd0, count}, n);
  endtask

  initial begin
    int d0, w0, tot;
    #2;
    chk("rst_rdy", {31'd0, in_ready}, 0);
    chk("rst_wr", {31'd0, wr}, 0);
    chk("rst_op", {24'd0, opcode}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_cnt", {24'd0, count}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("idle_rdy", {31'd0, in_ready}, 1);
    @(posedge clk); #1;

    // back-to-back burst
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    frame(3, 1'b0, 1'b0);
    chk("burst_span", last_wr - first_wr, 2);

    // full backpressure for 5 cycles after second write
    for (int i = 0; i < 4; i++) pl[i] = 8'h41 + 8'(i);
    w0 = wr_cnt;
    fork
      frame(4, 1'b0, 1'b0);
      begin
        int t = 0;
        while (wr_cnt < w0 + 2 && t < 100) begin @(negedge clk); #1; t++; end
        chk("full_trig", {31'd0, wr_cnt >= w0 + 2}, 1);
        @(posedge clk); #1 full = 1'b1;
        repeat (5) begin
          @(negedge clk);
          chk("full_wr", {31'd0, wr}, 0);
          chk("full_rdy", {31'd0, in_ready}, 0);
          @(posedge clk); #1;
        end
        full = 1'b0;
      end
    join

`ifdef LOADER_CHECKSUM_EN
    pl[0] = 8'hA5; pl[1] = 8'h0F;
    frame(2, 1'b0, 1'b0);
    frame(2, 1'b0, 1'b1);
`endif

    // zero-length header ignored
    d0 = done_cnt;
    send(8'h00);
    repeat (4) @(posedge clk);
    #1;
    chk("hdr0_nodone", done_cnt, d0);
    chk("hdr0_idle", {31'd0, busy}, 0);
    pl[0] = 8'h7E;
    frame(1, 1'b0, 1'b0);

    // reset in the middle of a program
    send(8'd5);
    send(8'hC1); exp_q.push_back(8'hC1);
    send(8'hC2); exp_q.push_back(8'hC2);
    reset = 1'b0;
    #1;
    chk("mid_rdy", {31'd0, in_ready}, 0);
    chk("mid_wr", {31'd0, wr}, 0);
    chk("mid_op", {24'd0, opcode}, 0);
    chk("mid_busy", {31'd0, busy}, 0);
    chk("mid_done", {31'd0, done}, 0);
    chk("mid_cnt", {24'd0, count}, 0);
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    pl[0] = 8'h01;
    frame(1, 1'b0, 1'b0);

    // maximum length with random host gaps
    for (int i = 0; i < 255; i++) pl[i] = 8'(i + 1);
    frame(255, 1'b1, 1'b0);

    tot = 3 + 4 + 1 + 1 + 1 + 255;
`ifdef LOADER_CHECKSUM_EN
    tot += 4;
`endif
    chk("wr_total", wr_cnt, tot);
    chk("q_final", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
